axi_lite_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank, the next-generation host interface for the neuromorphic ASIC bridge. Exposes N_REGS 32-bit registers to the PS: read/write control registers drive the network, PWM and LED logic; read-only status registers sample network outputs and XADC results. Adds features the current bridge slave lacks: AW and W accepted in either order, WSTRB byte enables, per-register read-only mask, SLVERR on bad or illegal accesses, and full B/R backpressure.

---
 rtl/axi_lite_pkg.sv | 21 ++
 rtl/axi_lite_strb_merge.sv | 18 +
 rtl/axi_lite_regbank.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bank.
// Holds the AXI response codes and the state encodings of the write and
// read channel state machines.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // The write channel collects AW and W in W_COLLECT, in any order, and
  // holds the response in W_RESP until the master accepts it.
  typedef enum logic {
    W_COLLECT = 1'b0,
    W_RESP    = 1'b1
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi_lite_strb_merge.sv
// Byte-enable merge of a 32-bit word.
// Ports:
//   old_data - current register contents
//   new_data - write data from the bus
//   strb     - byte enables; strb[b]=1 takes byte b from new_data
//   merged   - resulting word
module axi_lite_strb_merge (
  input  logic [31:0] old_data,
  input  logic [31:0] new_data,
  input  logic [3:0]  strb,
  output logic [31:0] merged
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign merged[gi*8 +: 8] = strb[gi] ? new_data[gi*8 +: 8] : old_data[gi*8 +: 8];
  end

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with N_REGS 32-bit registers.
// Read/write slots hold control values exposed on reg_out; read-only slots
// (RO_MASK bit set) return the matching status_in slice on reads.
// Ports:
//   S_AXI_*   - AXI4-Lite slave interface (AW/W/B write, AR/R read)
//   reg_out   - flattened register contents, slice i = reg_out[i*32 +: 32]
//   status_in - status words returned by read-only slots
//   wr_pulse  - one-cycle pulse per register on a successful write commit
//   rd_pulse  - one-cycle pulse per register on an OKAY read
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int                N_REGS     = 8,
  parameter int                ADDR_WIDTH = 9,
  parameter logic [N_REGS-1:0] RO_MASK    = '0,
  parameter logic [31:0]       RESET_VAL  = '0
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [N_REGS*32-1:0]   reg_out,
  input  logic [N_REGS*32-1:0]   status_in,
  output logic [N_REGS-1:0]      wr_pulse,
  output logic [N_REGS-1:0]      rd_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  // Write channel state
  wstate_e           wstate_q, wstate_d;
  logic              aw_cap_q, aw_cap_d;
  logic              w_cap_q, w_cap_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [N_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [31:0]       regs_q [N_REGS];
  logic [31:0]       regs_d [N_REGS];

  // Read channel state
  rstate_e           rstate_q, rstate_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [N_REGS-1:0] rd_pulse_q, rd_pulse_d;

  logic [IDX_W-1:0]  ar_idx;
  logic [N_REGS-1:0] wr_sel, ar_sel;
  logic [31:0]       merged [N_REGS];
  logic              aw_hs, w_hs, commit, wr_ok;
  logic              unused_addr_lsbs;

  // Byte lanes inside a word are selected by WSTRB, not by the address LSBs.
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // Per-register decode: an index with no matching slot is out of range,
  // so it selects nothing and the access falls through to SLVERR.
  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
    assign wr_sel[gi] = (aw_idx_q == IDX_W'(gi));
    assign ar_sel[gi] = (ar_idx == IDX_W'(gi));
    assign reg_out[gi*32 +: 32] = regs_q[gi];
    axi_lite_strb_merge u_merge (
      .old_data (regs_q[gi]),
      .new_data (wdata_q),
      .strb     (wstrb_q),
      .merged   (merged[gi])
    );
  end

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign commit = (wstate_q == W_COLLECT) && aw_cap_q && w_cap_q;
  assign wr_ok  = |(wr_sel & ~RO_MASK);

  // State register
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wstate_q   <= W_COLLECT;
      aw_cap_q   <= 1'b0;
      w_cap_q    <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= RESET_VAL;
      rstate_q   <= R_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      rd_pulse_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      aw_cap_q   <= aw_cap_d;
      w_cap_q    <= w_cap_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      rstate_q   <= rstate_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

  // Write channel next state
  always_comb begin
    wstate_d   = wstate_q;
    aw_cap_d   = aw_cap_q;
    w_cap_d    = w_cap_q;
    aw_idx_d   = aw_idx_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    case (wstate_q)
      W_COLLECT: begin
        if (commit) begin
          aw_cap_d = 1'b0;
          w_cap_d  = 1'b0;
          bvalid_d = 1'b1;
          wstate_d = W_RESP;
          if (wr_ok) begin
            bresp_d    = RESP_OKAY;
            wr_pulse_d = wr_sel & ~RO_MASK;
            for (int i = 0; i < N_REGS; i++) begin
              if (wr_sel[i] && !RO_MASK[i]) regs_d[i] = merged[i];
            end
          end else begin
            bresp_d = RESP_SLVERR;
          end
        end else begin
          // Ready is low for an already-captured half, so each half is
          // latched at most once per transaction.
          if (aw_hs) begin
            aw_cap_d = 1'b1;
            aw_idx_d = S_AXI_AWADDR[ADDR_WIDTH-1:2];
          end
          if (w_hs) begin
            w_cap_d = 1'b1;
            wdata_d = S_AXI_WDATA;
            wstrb_d = S_AXI_WSTRB;
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d = 1'b0;
          wstate_d = W_COLLECT;
        end
      end
      default: wstate_d = W_COLLECT;
    endcase
  end

  // Read channel next state. Reads see regs_q, so a read coinciding with a
  // write commit to the same slot returns the pre-write value.
  always_comb begin
    rstate_d   = rstate_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    case (rstate_q)
      R_IDLE: begin
        if (S_AXI_ARVALID) begin
          rvalid_d = 1'b1;
          rstate_d = R_DATA;
          if (|ar_sel) begin
            rresp_d    = RESP_OKAY;
            rd_pulse_d = ar_sel;
            rdata_d    = '0;
            for (int i = 0; i < N_REGS; i++) begin
              if (ar_sel[i]) rdata_d = RO_MASK[i] ? status_in[i*32 +: 32] : regs_q[i];
            end
          end else begin
            rresp_d = RESP_SLVERR;
            rdata_d = '0;
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    S_AXI_AWREADY = (wstate_q == W_COLLECT) && !aw_cap_q;
    S_AXI_WREADY  = (wstate_q == W_COLLECT) && !w_cap_q;
    S_AXI_ARREADY = (rstate_q == R_IDLE);
    S_AXI_BVALID  = bvalid_q;
    S_AXI_BRESP   = bresp_q;
    S_AXI_RVALID  = rvalid_q;
    S_AXI_RDATA   = rdata_q;
    S_AXI_RRESP   = rresp_q;
    wr_pulse      = wr_pulse_q;
    rd_pulse      = rd_pulse_q;
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed steps followed by
// random transactions, checked against a simple array model of the bank.
module tb_axi_lite_regbank;

  localparam int          N_REGS     = 8;
  localparam int          ADDR_WIDTH = 9;
  localparam logic [7:0]  RO         = 8'h02;
  localparam logic [31:0] RST_VAL    = 32'h5A5A_0000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic                  awvalid, awready, wvalid, wready;
  logic [31:0]           wdata, rdata;
  logic [3:0]            wstrb;
  logic [1:0]            bresp, rresp;
  logic                  bvalid, bready, arvalid, arready, rvalid, rready;
  logic [N_REGS*32-1:0]  reg_out, status_in;
  logic [N_REGS-1:0]     wr_pulse, rd_pulse;

  axi_lite_regbank #(
    .N_REGS(N_REGS), .ADDR_WIDTH(ADDR_WIDTH), .RO_MASK(RO), .RESET_VAL(RST_VAL)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model  [N_REGS];
  logic [31:0] status [N_REGS];
  logic [7:0]  ro_mask = RO;

  always_comb begin
    status_in = '0;
    for (int i = 0; i < N_REGS; i++) status_in[i*32 +: 32] = status[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: word index from the address, bytes merged by strobe.
  task automatic model_write(input logic [8:0] addr, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output logic [7:0] pulse);
    int idx = int'(addr) / 4;
    pulse = '0;
    if (idx >= N_REGS || ro_mask[idx]) begin
      resp = 2'b10;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      resp = 2'b00;
      pulse[idx] = 1'b1;
    end
  endtask

  task automatic model_read(input logic [8:0] addr, output logic [31:0] d,
                            output logic [1:0] resp, output logic [7:0] pulse);
    int idx = int'(addr) / 4;
    pulse = '0;
    if (idx >= N_REGS) begin
      d = 32'h0; resp = 2'b10;
    end else begin
      d = ro_mask[idx] ? status[idx] : model[idx];
      resp = 2'b00;
      pulse[idx] = 1'b1;
    end
  endtask

  // Compare read/write slots of reg_out with the model.
  task automatic chk_regs(input string tag);
    logic [N_REGS*32-1:0] exp_flat, obs_flat;
    for (int i = 0; i < N_REGS; i++) begin
      exp_flat[i*32 +: 32] = ro_mask[i] ? 32'h0 : model[i];
      obs_flat[i*32 +: 32] = ro_mask[i] ? 32'h0 : reg_out[i*32 +: 32];
    end
    n_checks++;
    assert (obs_flat === exp_flat) else begin
      n_fail++;
      $error("FAIL %s/reg_out: observed=%0h expected=%0h", tag, obs_flat, exp_flat);
    end
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input string tag);
    logic aw_done = 1'b0, w_done = 1'b0, aw_fire, w_fire;
    logic [1:0] exp_resp;
    logic [7:0] exp_pulse;
    int hs_cyc = 0;
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && n < 60) begin
      awvalid = !aw_done && (n >= aw_dly);
      wvalid  = !w_done && (n >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      n++;
      if (aw_fire) begin aw_done = 1'b1; hs_cyc = cyc; end
      if (w_fire)  begin w_done = 1'b1;  hs_cyc = cyc; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, "/handshakes"}, 64'(aw_done && w_done), 64'd1);
    model_write(addr, data, strb, exp_resp, exp_pulse);
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "/b_latency"}, 64'(cyc - hs_cyc), 64'd1);
    chk({tag, "/wr_pulse"}, 64'(wr_pulse), 64'(exp_pulse));
    chk_regs(tag);
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); #1;
      chk({tag, "/b_stall"}, 64'({bvalid, awready, wready, wr_pulse}), 64'({3'b100, 8'h00}));
    end
    chk({tag, "/bresp"}, 64'(bresp), 64'(exp_resp));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    chk({tag, "/b_done"}, 64'({bvalid, awready, wready, wr_pulse}), 64'({3'b011, 8'h00}));
    $display("write %s addr=%03h data=%08h strb=%b resp=%b", tag, addr, data, strb, exp_resp);
  endtask

  task automatic do_read(input logic [8:0] addr, input int r_dly, input string tag);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
    int idx = int'(addr) / 4;
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    model_read(addr, exp_data, exp_resp, exp_pulse);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk({tag, "/rvalid"}, 64'(rvalid), 64'd1);
    chk({tag, "/rdata"}, 64'(rdata), 64'(exp_data));
    chk({tag, "/rresp"}, 64'(rresp), 64'(exp_resp));
    chk({tag, "/rd_pulse"}, 64'(rd_pulse), 64'(exp_pulse));
    for (int k = 0; k < r_dly; k++) begin
      // Disturb the status source: a captured read must not follow it.
      if (idx < N_REGS) status[idx] = status[idx] ^ 32'h0F0F_F0F0;
      @(posedge clk); #1;
      chk({tag, "/r_stall"}, 64'({rvalid, arready, rd_pulse, rdata}), 64'({2'b10, 8'h00, exp_data}));
    end
    if (idx < N_REGS && (r_dly % 2 == 1)) status[idx] = status[idx] ^ 32'h0F0F_F0F0;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    chk({tag, "/r_done"}, 64'({rvalid, arready}), 64'(2'b01));
    $display("read  %s addr=%03h data=%08h resp=%b", tag, addr, exp_data, exp_resp);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < N_REGS; i++) begin
      status[i] = $urandom;
      model[i]  = RST_VAL;
    end
    status[1] = 32'hCAFE_0001;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("reset/ready", 64'({awready, wready, arready}), 64'(3'b111));
    chk("reset/valid_resp", 64'({bvalid, rvalid, bresp, rresp}), 64'd0);
    chk("reset/rdata", 64'(rdata), 64'd0);
    chk("reset/pulses", 64'({wr_pulse, rd_pulse}), 64'd0);
    chk_regs("reset");

    // Write then read every slot
    for (int i = 0; i < N_REGS; i++) begin
      do_write(9'(4*i), 32'hDEAD_BEEF, 4'hF, 0, 0, 0, $sformatf("wr_rd%0d", i));
      do_read(9'(4*i), 0, $sformatf("wr_rd%0d", i));
    end

    // W leads AW by three cycles
    do_write(9'h008, 32'h1234_5678, 4'hF, 3, 0, 0, "w_first");
    do_read(9'h008, 0, "w_first");
    // AW leads W
    do_write(9'h018, 32'hA1B2_C3D4, 4'hF, 0, 2, 0, "aw_first");

    // Byte strobes
    do_write(9'h00C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "strb_fill");
    do_write(9'h00C, 32'h0000_0000, 4'b0101, 0, 0, 0, "strb_0101");
    chk("strb_0101/value", 64'(reg_out[3*32 +: 32]), 64'h0000_0000_FF00_FF00);
    do_read(9'h00E, 0, "strb_0101");
    do_write(9'h010, 32'h1111_1111, 4'b0000, 0, 0, 0, "strb_none");

    // Illegal accesses
    do_write(9'h004, 32'h0000_0000, 4'hF, 0, 0, 0, "ro_write");
    do_read(9'h004, 0, "ro_read");
    do_read(9'h040, 0, "oor_read");
    do_write(9'h040, 32'h5555_5555, 4'hF, 1, 0, 0, "oor_write");

    // Backpressure
    do_read(9'h008, 5, "r_bp");
    do_read(9'h004, 5, "r_bp_ro");
    do_write(9'h014, 32'h0BAD_F00D, 4'hF, 0, 0, 4, "b_bp");

    // Reset in the middle of a write: AW taken, W never sent
    awaddr = 9'h01C; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("mid_rst/aw_captured", 64'({awready, wready}), 64'(2'b01));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N_REGS; i++) model[i] = RST_VAL;
    for (int k = 0; k < 3; k++) begin
      chk("mid_rst/no_b", 64'({bvalid, awready, wready, wr_pulse}), 64'({3'b011, 8'h00}));
      @(posedge clk); #1;
    end
    chk_regs("mid_rst");
    do_write(9'h01C, 32'h7777_8888, 4'hF, 0, 0, 0, "after_rst");
    do_read(9'h01C, 0, "after_rst");

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      do_write(9'($urandom_range(0, 'h4F)), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
               $sformatf("rnd%0d", t));
      do_read(9'($urandom_range(0, 'h4F)), $urandom_range(0, 2), $sformatf("rnd%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
